// File: rtl/interrupt_8259a_pkg.sv
// Shared types and constants for the 8259A interrupt acknowledge sequencer.
package interrupt_8259a_pkg;

  // Acknowledge sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK1 = 2'd2,
    ST_ACK2 = 2'd3
  } ack_state_t;

  // Legal INTA pulse counts per acknowledge cycle
  localparam int ACK_PULSES_8086   = 2;
  localparam int ACK_PULSES_SINGLE = 1;

  // Level reported when an acknowledge finds no valid request
  localparam logic [2:0] SPURIOUS_INDEX = 3'd7;

  // Returns {found, level} of the highest-priority set bit, where
  // level 'rot' is the highest priority and priority falls with (level - rot) mod 8.
  function automatic logic [3:0] highest_priority(input logic [7:0] vec,
                                                  input logic [2:0] rot);
    logic [3:0] result;
    logic [2:0] lvl;
    result = 4'b0000;
    // Scan from lowest priority upwards so the last hit is the highest priority.
    for (int k = 7; k >= 0; k--) begin
      lvl = rot + 3'(k);
      if (vec[lvl]) begin
        result = {1'b1, lvl};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/priority_resolver_8259a.sv
// Combinational priority resolver: picks the highest-priority unmasked request
// and decides whether it outranks everything currently in service.
module priority_resolver_8259a
  import interrupt_8259a_pkg::*;
(
  input  logic [7:0] candidates,
  input  logic [7:0] in_service,
  input  logic [2:0] rotation,
  output logic [2:0] winner,
  output logic       request_valid
);

  // Vectors re-indexed by priority rank (rank 0 = highest priority).
  logic [7:0] cand_by_rank;
  logic [7:0] isr_by_rank;
  logic [3:0] cand_best;
  logic [3:0] isr_best;

  for (genvar gi = 0; gi < 8; gi++) begin : g_rank
    assign cand_by_rank[gi] = candidates[rotation + 3'(gi)];
    assign isr_by_rank[gi]  = in_service[rotation + 3'(gi)];
  end

  // Rank of the best candidate and of the best in-service level.
  assign cand_best = highest_priority(cand_by_rank, 3'd0);
  assign isr_best  = highest_priority(isr_by_rank, 3'd0);

  assign winner = rotation + cand_best[2:0];

  // Fully nested: a request only qualifies if strictly above every in-service level.
  assign request_valid = cand_best[3] &&
                         (!isr_best[3] || (cand_best[2:0] < isr_best[2:0]));

endmodule

// File: rtl/interrupt_ack_sequencer_8259a.sv
// 8259A interrupt acknowledge sequencer: raises INT, runs the INTA pulse
// sequence, maintains the ISR and presents the vector byte.
// Optional feature: define ROTATING_PRIORITY_EN to make a non-specific EOI
// rotate priority (cleared level becomes lowest). Undefined = fixed priority.
module interrupt_ack_sequencer_8259a
  import interrupt_8259a_pkg::*;
#(
  parameter int ACK_PULSES = ACK_PULSES_8086
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic [4:0] vector_base,
  input  logic       interrupt_acknowledge_n,
  input  logic       end_of_interrupt,
  input  logic       specific_eoi,
  input  logic [2:0] eoi_level,
  output logic       interrupt_to_cpu,
  output logic       freeze,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] in_service_register,
  output logic [7:0] out_data,
  output logic       out_data_valid
);

  // State entered on the first INTA falling edge.
  localparam ack_state_t FIRST_ACK_STATE =
    (ACK_PULSES == ACK_PULSES_SINGLE) ? ST_ACK2 : ST_ACK1;

  ack_state_t state_reg;
  logic       int_reg;
  logic       freeze_reg;
  logic [7:0] clear_reg;
  logic [7:0] isr_reg;
  logic [2:0] index_reg;
  logic [7:0] data_reg;
  logic       data_valid_reg;
  logic       inta_prev_reg;
  logic [2:0] rotation;

  logic [7:0] candidates;
  logic [2:0] winner;
  logic       request_valid;
  logic       inta_fall;
  logic       inta_rise;
  logic       ack_take;
  logic [2:0] take_index;
  logic [7:0] set_mask;
  logic [7:0] eoi_mask;
  logic [3:0] eoi_best;

  assign candidates = interrupt_request_register & ~interrupt_mask;

  priority_resolver_8259a u_resolver (
    .candidates    (candidates),
    .in_service    (isr_reg),
    .rotation      (rotation),
    .winner        (winner),
    .request_valid (request_valid)
  );

  assign inta_fall  = inta_prev_reg & ~interrupt_acknowledge_n;
  assign inta_rise  = ~inta_prev_reg & interrupt_acknowledge_n;
  assign ack_take   = (state_reg == ST_REQ) && inta_fall;
  assign take_index = request_valid ? winner : SPURIOUS_INDEX;
  assign set_mask   = (ack_take && request_valid) ? (8'b1 << winner) : 8'h00;

  // Select the ISR bit an EOI strobe clears (none if no matching bit is set).
  always_comb begin
    eoi_mask = 8'h00;
    eoi_best = highest_priority(isr_reg, rotation);
    if (end_of_interrupt) begin
      if (specific_eoi) begin
        eoi_mask = 8'b1 << eoi_level;
      end else if (eoi_best[3]) begin
        eoi_mask = 8'b1 << eoi_best[2:0];
      end
    end
  end

`ifdef ROTATING_PRIORITY_EN
  logic [2:0] rotation_reg;

  // Non-specific EOI makes the cleared level lowest priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rotation_reg <= 3'd0;
    end else if (end_of_interrupt && !specific_eoi && eoi_best[3]) begin
      rotation_reg <= eoi_best[2:0] + 3'd1;
    end
  end

  assign rotation = rotation_reg;
`else
  assign rotation = 3'd0;
`endif

  // ISR update: EOI clear first, then acknowledge set, so a set wins on the same bit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      isr_reg <= 8'h00;
    end else begin
      isr_reg <= (isr_reg & ~eoi_mask) | set_mask;
    end
  end

  // Acknowledge FSM with registered INT, freeze, clear pulse and vector outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      int_reg        <= 1'b0;
      freeze_reg     <= 1'b0;
      clear_reg      <= 8'h00;
      index_reg      <= 3'd0;
      data_reg       <= 8'h00;
      data_valid_reg <= 1'b0;
      inta_prev_reg  <= 1'b1;
    end else begin
      inta_prev_reg <= interrupt_acknowledge_n;
      clear_reg     <= set_mask;
      case (state_reg)
        ST_IDLE: begin
          if (request_valid) begin
            state_reg <= ST_REQ;
            int_reg   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (inta_fall) begin
            int_reg    <= 1'b0;
            freeze_reg <= 1'b1;
            index_reg  <= take_index;
            state_reg  <= FIRST_ACK_STATE;
            if (FIRST_ACK_STATE == ST_ACK2) begin
              data_valid_reg <= 1'b1;
              data_reg       <= {vector_base, take_index};
            end
          end else if (!request_valid) begin
            state_reg <= ST_IDLE;
            int_reg   <= 1'b0;
          end
        end
        ST_ACK1: begin
          if (inta_fall) begin
            state_reg      <= ST_ACK2;
            data_valid_reg <= 1'b1;
            data_reg       <= {vector_base, index_reg};
          end
        end
        ST_ACK2: begin
          if (inta_rise) begin
            state_reg      <= ST_IDLE;
            freeze_reg     <= 1'b0;
            data_valid_reg <= 1'b0;
            data_reg       <= 8'h00;
          end else begin
            data_reg <= {vector_base, index_reg};
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign interrupt_to_cpu        = int_reg;
  assign freeze                  = freeze_reg;
  assign clear_interrupt_request = clear_reg;
  assign in_service_register     = isr_reg;
  assign out_data                = data_reg;
  assign out_data_valid          = data_valid_reg;

endmodule

// File: tb/tb_interrupt_ack_sequencer_8259a.sv
// Directed bench for interrupt_ack_sequencer_8259a (ACK_PULSES = 2).
module tb_interrupt_ack_sequencer_8259a;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irr = 8'h00;
  logic [7:0] imr = 8'h00;
  logic [4:0] vector_base = 5'b01000;
  logic       inta_n = 1'b1;
  logic       eoi = 1'b0;
  logic       specific = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic       int_out;
  logic       freeze;
  logic [7:0] clear_req;
  logic [7:0] isr;
  logic [7:0] out_data;
  logic       out_valid;

  int asserts_evaluated = 0;
  int failures = 0;

  interrupt_ack_sequencer_8259a #(.ACK_PULSES(2)) dut (
    .clock                      (clock),
    .reset_n                    (reset_n),
    .interrupt_request_register (irr),
    .interrupt_mask             (imr),
    .vector_base                (vector_base),
    .interrupt_acknowledge_n    (inta_n),
    .end_of_interrupt           (eoi),
    .specific_eoi               (specific),
    .eoi_level                  (eoi_level),
    .interrupt_to_cpu           (int_out),
    .freeze                     (freeze),
    .clear_interrupt_request    (clear_req),
    .in_service_register        (isr),
    .out_data                   (out_data),
    .out_data_valid             (out_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    asserts_evaluated++;
    assert (observed === expected)
      $display("[%0t] %s observed=0x%02h expected=0x%02h ok", $time, tag, observed, expected);
    else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset values, checked asynchronously before any clock edge.
    #3;
    check("rst_int", {7'd0, int_out}, 8'h00);
    check("rst_freeze", {7'd0, freeze}, 8'h00);
    check("rst_clear", clear_req, 8'h00);
    check("rst_isr", isr, 8'h00);
    check("rst_data", out_data, 8'h00);
    check("rst_valid", {7'd0, out_valid}, 8'h00);
    reset_n = 1'b1;
    step();

    // Basic acknowledge: IRR=24 -> IR2 wins, vector 0x42.
    irr = 8'h24;
    step();
    check("s1_int_raised", {7'd0, int_out}, 8'h01);
    inta_n = 1'b0;
    step();
    check("s1_isr", isr, 8'h04);
    check("s1_clear", clear_req, 8'h04);
    check("s1_freeze", {7'd0, freeze}, 8'h01);
    check("s1_int_dropped", {7'd0, int_out}, 8'h00);
    check("s1_valid_pulse1", {7'd0, out_valid}, 8'h00);
    irr = 8'h20;
    inta_n = 1'b1;
    step();
    check("s1_clear_one_cycle", clear_req, 8'h00);
    inta_n = 1'b0;
    step();
    check("s1_vector", out_data, 8'h42);
    check("s1_valid", {7'd0, out_valid}, 8'h01);
    inta_n = 1'b1;
    step();
    check("s1_end_valid", {7'd0, out_valid}, 8'h00);
    check("s1_end_data", out_data, 8'h00);
    check("s1_end_freeze", {7'd0, freeze}, 8'h00);

    // Fully nested: IR3 under IR2 in service does not qualify; IR0 does.
    irr = 8'h08;
    step();
    step();
    check("s2_lower_no_int", {7'd0, int_out}, 8'h00);
    irr = 8'h01;
    step();
    check("s2_higher_int", {7'd0, int_out}, 8'h01);
    inta_n = 1'b0;
    step();
    check("s2_isr", isr, 8'h05);
    check("s2_clear", clear_req, 8'h01);
    irr = 8'h08;
    inta_n = 1'b1;
    step();
    inta_n = 1'b0;
    step();
    check("s2_vector", out_data, 8'h40);
    inta_n = 1'b1;
    step();

    // Non-specific EOI clears IR0, then specific EOI clears IR2.
    eoi = 1'b1;
    specific = 1'b0;
    step();
    check("s4_nonspecific", isr, 8'h04);
    specific = 1'b1;
    eoi_level = 3'd2;
    step();
    eoi = 1'b0;
    specific = 1'b0;
    check("s4_specific", isr, 8'h00);

    // Spurious: request vanishes at the first INTA edge.
    step();
    check("s3_int", {7'd0, int_out}, 8'h01);
    irr = 8'h00;
    inta_n = 1'b0;
    step();
    check("s3_isr", isr, 8'h00);
    check("s3_clear", clear_req, 8'h00);
    check("s3_freeze", {7'd0, freeze}, 8'h01);
    inta_n = 1'b1;
    step();
    inta_n = 1'b0;
    step();
    check("s3_vector", out_data, 8'h47);
    check("s3_valid", {7'd0, out_valid}, 8'h01);
    inta_n = 1'b1;
    step();
    check("s3_data_zero", out_data, 8'h00);

    // Request withdrawn before INTA drops INT; INTA in IDLE is ignored.
    irr = 8'h08;
    step();
    check("s5_int", {7'd0, int_out}, 8'h01);
    irr = 8'h00;
    step();
    check("s5_int_withdrawn", {7'd0, int_out}, 8'h00);
    inta_n = 1'b0;
    step();
    check("s5_idle_edge_freeze", {7'd0, freeze}, 8'h00);
    check("s5_idle_edge_isr", isr, 8'h00);
    inta_n = 1'b1;
    step();

    // Serve IR3, non-specific EOI, then IRR=18.
    irr = 8'h08;
    step();
    inta_n = 1'b0;
    step();
    check("s6_isr_ir3", isr, 8'h08);
    irr = 8'h00;
    inta_n = 1'b1;
    step();
    inta_n = 1'b0;
    step();
    check("s6_vector", out_data, 8'h43);
    inta_n = 1'b1;
    step();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    check("s6_eoi", isr, 8'h00);
    irr = 8'h18;
    step();
    check("s6_int", {7'd0, int_out}, 8'h01);
    inta_n = 1'b0;
    step();
`ifdef ROTATING_PRIORITY_EN
    check("s6_winner_isr", isr, 8'h10);
    check("s6_winner_clear", clear_req, 8'h10);
`else
    check("s6_winner_isr", isr, 8'h08);
    check("s6_winner_clear", clear_req, 8'h08);
`endif

    // Reset asserted while in ACK1: all outputs clear immediately.
    reset_n = 1'b0;
    #1;
    check("s7_int", {7'd0, int_out}, 8'h00);
    check("s7_freeze", {7'd0, freeze}, 8'h00);
    check("s7_clear", clear_req, 8'h00);
    check("s7_isr", isr, 8'h00);
    check("s7_data", out_data, 8'h00);
    check("s7_valid", {7'd0, out_valid}, 8'h00);
    irr = 8'h00;
    #2;
    reset_n = 1'b1;
    // INTA still low: first post-reset edge seen from IDLE, ignored.
    step();
    check("s7_post_freeze", {7'd0, freeze}, 8'h00);
    check("s7_post_valid", {7'd0, out_valid}, 8'h00);
    inta_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_evaluated, failures);
    $finish;
  end

endmodule
